// File: rtl/cpu_clock_ctrl_if.sv
// Board-side signal bundle for the CPU clock/reset front end.
// master drives the raw board inputs; slave is the clock controller.
interface cpu_clock_ctrl_if;
  logic        btn_step;
  logic        btn_reset;
  logic        sw_run;
  logic [7:0]  sw_sel;
  logic        cpu_clk;
  logic        cpu_rst;
  logic [7:0]  led_sel;
  logic [31:0] cycle_count;

  modport master (
    output btn_step, btn_reset, sw_run, sw_sel,
    input  cpu_clk, cpu_rst, led_sel, cycle_count
  );

  modport slave (
    input  btn_step, btn_reset, sw_run, sw_sel,
    output cpu_clk, cpu_rst, led_sel, cycle_count
  );
endinterface

// File: rtl/cpu_clock_ctrl.sv
// CPU clock/reset generator: synchronizes and debounces board inputs, then
// issues a registered single-step or free-running CPU clock and a held reset.
module cpu_clock_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned RUN_HALF_PERIOD = 2,
  parameter int unsigned RESET_PULSES    = 2
) (
  input  logic            clk,
  input  logic            rst,
  cpu_clock_ctrl_if.slave bus
);

  localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned PW = (RUN_HALF_PERIOD > 1) ? $clog2(RUN_HALF_PERIOD) : 1;
  localparam int unsigned CW = $clog2(RESET_PULSES + 1);

  typedef enum logic [2:0] {
    RST_HOLD,
    IDLE,
    STEP_HI,
    STEP_LO,
    RUN
  } state_t;

  // bit 0 btn_step, bit 1 btn_reset, bit 2 sw_run, bits 10:3 sw_sel
  logic [10:0]         sync1_q, sync2_q;
  logic [2:0]          db_q, db_d;
  logic [2:0][DW-1:0]  db_cnt_q, db_cnt_d;
  logic [7:0]          led_sel_q;
  logic                step_prev_q, reset_prev_q;
  logic                step_press, reset_rise;

  state_t              state_q, state_d;
  logic [PW-1:0]       phase_q, phase_d;
  logic [CW-1:0]       pulses_q, pulses_d;
  logic                pending_q, pending_d;
  logic                cpu_clk_q, cpu_clk_d;
  logic                cpu_rst_q, cpu_rst_d;
  logic [31:0]         count_q, count_d;
  logic                phase_end, low_end, rst_entry;

  always_comb begin
    db_d     = db_q;
    db_cnt_d = db_cnt_q;
    for (int unsigned i = 0; i < 3; i++) begin
      if (sync2_q[i] != db_q[i]) begin
        if (db_cnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          db_d[i]     = sync2_q[i];
          db_cnt_d[i] = '0;
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end else begin
        db_cnt_d[i] = '0;
      end
    end
  end

  assign step_press = db_q[0] & ~step_prev_q;
  assign reset_rise = db_q[1] & ~reset_prev_q;
  assign phase_end  = (phase_q == PW'(RUN_HALF_PERIOD - 1));
  assign low_end    = phase_end & ~cpu_clk_q;

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_end ? '0 : phase_q + 1'b1;
    pulses_d  = pulses_q;
    cpu_clk_d = cpu_clk_q;
    case (state_q)
      RST_HOLD: begin
        if (low_end && pulses_q == CW'(RESET_PULSES) && !db_q[1]) begin
          state_d   = IDLE;
          cpu_clk_d = 1'b0;
        end else if (phase_end) begin
          cpu_clk_d = ~cpu_clk_q;
          if (!cpu_clk_q && pulses_q != CW'(RESET_PULSES))
            pulses_d = pulses_q + 1'b1;
        end
      end
      IDLE: begin
        phase_d   = '0;
        cpu_clk_d = 1'b0;
        if (pending_q) begin
          state_d  = RST_HOLD;
          pulses_d = '0;
        end else if (db_q[2]) begin
          state_d   = RUN;
          cpu_clk_d = 1'b1;
        end else if (step_press) begin
          state_d   = STEP_HI;
          cpu_clk_d = 1'b1;
        end
      end
      STEP_HI: begin
        if (phase_end) begin
          state_d   = STEP_LO;
          cpu_clk_d = 1'b0;
        end
      end
      STEP_LO: begin
        if (phase_end) state_d = IDLE;
      end
      RUN: begin
        // Leave only once a full low phase has completed.
        if (low_end && (!db_q[2] || pending_q)) begin
          state_d   = pending_q ? RST_HOLD : IDLE;
          pulses_d  = '0;
          cpu_clk_d = 1'b0;
        end else if (phase_end) begin
          cpu_clk_d = ~cpu_clk_q;
        end
      end
      default: begin
        state_d   = RST_HOLD;
        pulses_d  = '0;
        cpu_clk_d = 1'b0;
      end
    endcase
  end

  assign rst_entry = (state_d == RST_HOLD) && (state_q != RST_HOLD);
  assign pending_d = reset_rise | (pending_q & ~rst_entry);
  assign cpu_rst_d = (state_d == RST_HOLD);

  always_comb begin
    count_d = count_q;
    if (cpu_rst_d)                   count_d = '0;
    else if (cpu_clk_d & ~cpu_clk_q) count_d = count_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      db_q         <= '0;
      db_cnt_q     <= '0;
      led_sel_q    <= '0;
      step_prev_q  <= 1'b0;
      reset_prev_q <= 1'b0;
      state_q      <= RST_HOLD;
      phase_q      <= '0;
      pulses_q     <= '0;
      pending_q    <= 1'b0;
      cpu_clk_q    <= 1'b0;
      cpu_rst_q    <= 1'b1;
      count_q      <= '0;
    end else begin
      sync1_q      <= {bus.sw_sel, bus.sw_run, bus.btn_reset, bus.btn_step};
      sync2_q      <= sync1_q;
      db_q         <= db_d;
      db_cnt_q     <= db_cnt_d;
      led_sel_q    <= sync2_q[10:3];
      step_prev_q  <= db_q[0];
      reset_prev_q <= db_q[1];
      state_q      <= state_d;
      phase_q      <= phase_d;
      pulses_q     <= pulses_d;
      pending_q    <= pending_d;
      cpu_clk_q    <= cpu_clk_d;
      cpu_rst_q    <= cpu_rst_d;
      count_q      <= count_d;
    end
  end

  assign bus.cpu_clk     = cpu_clk_q;
  assign bus.cpu_rst     = cpu_rst_q;
  assign bus.led_sel     = led_sel_q;
  assign bus.cycle_count = count_q;

endmodule
